// File: rtl/ann_pkg.sv
// Shared constants for the mine-detection ANN front end: feature format, frame size, error bits.
package ann_pkg;

  localparam int BROJ_ZNACAJKI     = 60;
  localparam int SIRINA            = 16;
  localparam int BIT_ZNAKA         = 15;
  localparam int SIRINA_UZORKA     = BROJ_ZNACAJKI * SIRINA;
  localparam int SIRINA_INDEKSA    = 6;
  localparam int GRESKA_PORAVNANJE = 0;
  localparam int GRESKA_NEGATIVNA  = 1;

endpackage

// File: rtl/uzorak_loader_if.sv
// Feature input stream and assembled-frame output stream of the uzorak loader.
interface uzorak_loader_if;
  import ann_pkg::*;

  logic [SIRINA-1:0]        znacajka;
  logic                     znacajka_valid;
  logic                     znacajka_ready;
  logic                     prvi;
  logic [SIRINA_UZORKA-1:0] uzorak;
  logic                     uzorak_valid;
  logic                     uzorak_ready;

  modport master (
    output znacajka, znacajka_valid, prvi, uzorak_ready,
    input  znacajka_ready, uzorak, uzorak_valid
  );

  modport slave (
    input  znacajka, znacajka_valid, prvi, uzorak_ready,
    output znacajka_ready, uzorak, uzorak_valid
  );
endinterface

// File: rtl/uzorak_loader.sv
// Assembles 60 sign-magnitude features into one 960-bit frame; frame valid the cycle after the 60th beat.
// Only the final beat of a frame stalls, and only while the previous frame is still unconsumed.
module uzorak_loader
  import ann_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  uzorak_loader_if.slave            bus,
  input  logic                      brisi_gresku,
  output logic [SIRINA_INDEKSA-1:0] indeks,
  output logic [1:0]                greska
);

  localparam logic [SIRINA_INDEKSA-1:0] ZADNJI = SIRINA_INDEKSA'(BROJ_ZNACAJKI - 1);

  // Negative features (including negative zero) are not meaningful to the layer and become zero.
  function automatic logic [SIRINA-1:0] ogranici(input logic [SIRINA-1:0] z);
    return z[BIT_ZNAKA] ? '0 : z;
  endfunction

  logic [SIRINA_UZORKA-SIRINA-1:0] bafer;
  logic [SIRINA_INDEKSA-1:0]       idx_upis;
  logic [SIRINA-1:0]               vrednost;
  logic [1:0]                      greska_set;
  logic                            prijem;
  logic                            kraj;

  assign bus.znacajka_ready = !(indeks == ZADNJI && bus.uzorak_valid && !bus.uzorak_ready);
  assign prijem   = bus.znacajka_valid && bus.znacajka_ready;
  assign idx_upis = bus.prvi ? '0 : indeks;
  assign kraj     = prijem && (idx_upis == ZADNJI);
  assign vrednost = ogranici(bus.znacajka);

  assign greska_set[GRESKA_PORAVNANJE] = prijem && bus.prvi && (indeks != '0);
  assign greska_set[GRESKA_NEGATIVNA]  = prijem && bus.znacajka[BIT_ZNAKA];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      indeks           <= '0;
      bafer            <= '0;
      bus.uzorak       <= '0;
      bus.uzorak_valid <= 1'b0;
      greska           <= '0;
    end else begin
      greska <= (brisi_gresku ? 2'b00 : greska) | greska_set;
      if (kraj) begin
        // The last feature bypasses the buffer straight into the top slot of the frame.
        bus.uzorak       <= {vrednost, bafer};
        bus.uzorak_valid <= 1'b1;
        indeks           <= '0;
      end else begin
        if (bus.uzorak_ready) bus.uzorak_valid <= 1'b0;
        if (prijem) begin
          bafer[int'(idx_upis) * SIRINA +: SIRINA] <= vrednost;
          indeks <= idx_upis + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uzorak_loader.sv
// Directed bench for uzorak_loader: vector table for per-beat index/error behaviour plus frame sequences.
module tb_uzorak_loader;
  import ann_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       brisi_gresku = 1'b0;
  logic [5:0] indeks;
  logic [1:0] greska;

  int n_checks = 0;
  int n_errors = 0;

  uzorak_loader_if bus ();

  uzorak_loader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .brisi_gresku (brisi_gresku),
    .indeks       (indeks),
    .greska       (greska)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [15:0] z;
    logic        p;
    logic        br;
    logic [5:0]  idx;
    logic [1:0]  g;
  } vek_t;

  vek_t tab [10];

  task automatic chk(input string ime, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", ime, act, exp);
    end
  endtask

  function automatic logic [15:0] slot(input int k);
    return bus.uzorak[k*16 +: 16];
  endfunction

  task automatic korak(input logic v, input logic [15:0] z, input logic p,
                       input logic br, input logic ur);
    bus.znacajka_valid = v;
    bus.znacajka       = z;
    bus.prvi           = p;
    brisi_gresku       = br;
    bus.uzorak_ready   = ur;
    @(posedge clk);
    #1;
    bus.znacajka_valid = 1'b0;
    bus.prvi           = 1'b0;
    brisi_gresku       = 1'b0;
  endtask

  // Full frame; slot neg_idx (if < 60) carries a negative feature instead.
  task automatic posalji_okvir(input logic [15:0] baza, input logic ur, input int neg_idx);
    for (int k = 0; k < 60; k++)
      korak(1'b1, (k == neg_idx) ? 16'h8123 : baza + 16'(k), k == 0, 1'b0, ur);
  endtask

  task automatic chk_okvir(input string ime, input logic [15:0] baza);
    int los = 0;
    int prvi_los = -1;
    for (int k = 0; k < 60; k++) begin
      if (slot(k) !== baza + 16'(k)) begin
        los++;
        if (prvi_los < 0) prvi_los = k;
      end
    end
    n_checks++;
    if (los != 0) begin
      n_errors++;
      $display("FAIL %s: %0d bad slots, slot %0d got %0h expected %0h", ime, los, prvi_los,
               slot(prvi_los), baza + 16'(prvi_los));
    end
  endtask

  initial begin
    int nestabilno;

    tab[0] = '{1'b1, 16'h0010, 1'b1, 1'b0, 6'd1, 2'd0};
    tab[1] = '{1'b1, 16'h0011, 1'b0, 1'b0, 6'd2, 2'd0};
    tab[2] = '{1'b1, 16'h8000, 1'b0, 1'b0, 6'd3, 2'd2};
    tab[3] = '{1'b1, 16'h0013, 1'b0, 1'b1, 6'd4, 2'd0};
    tab[4] = '{1'b1, 16'h8123, 1'b0, 1'b1, 6'd5, 2'd2};
    tab[5] = '{1'b1, 16'h0015, 1'b1, 1'b0, 6'd1, 2'd3};
    tab[6] = '{1'b1, 16'h0016, 1'b0, 1'b1, 6'd2, 2'd0};
    tab[7] = '{1'b0, 16'h8000, 1'b1, 1'b0, 6'd2, 2'd0};
    tab[8] = '{1'b1, 16'h0017, 1'b1, 1'b0, 6'd1, 2'd1};
    tab[9] = '{1'b1, 16'h0018, 1'b0, 1'b1, 6'd2, 2'd0};

    bus.znacajka       = '0;
    bus.znacajka_valid = 1'b0;
    bus.prvi           = 1'b0;
    bus.uzorak_ready   = 1'b0;

    // Reset state
    #12;
    chk("rst_indeks", indeks, 0);
    chk("rst_valid", bus.uzorak_valid, 0);
    chk("rst_greska", greska, 0);
    chk("rst_uzorak_zero", bus.uzorak == '0, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rdy_after_rst", bus.znacajka_ready, 1);

    // Basic frame 1..60
    for (int k = 0; k < 59; k++) korak(1'b1, 16'(k + 1), k == 0, 1'b0, 1'b1);
    chk("valid_before_60th", bus.uzorak_valid, 0);
    chk("indeks_59", indeks, 59);
    korak(1'b1, 16'h003C, 1'b0, 1'b0, 1'b1);
    chk("f1_valid", bus.uzorak_valid, 1);
    chk("f1_slot0", slot(0), 16'h0001);
    chk("f1_slot59", slot(59), 16'h003C);
    chk("f1_greska", greska, 0);
    chk("f1_indeks", indeks, 0);
    chk_okvir("f1_frame", 16'h0001);
    korak(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    chk("f1_valid_pulse", bus.uzorak_valid, 0);
    chk("f1_hold_after_take", slot(0), 16'h0001);

    // Per-beat index / error vectors
    for (int i = 0; i < 10; i++) begin
      korak(tab[i].v, tab[i].z, tab[i].p, tab[i].br, 1'b1);
      chk($sformatf("vec%0d_indeks", i), indeks, tab[i].idx);
      chk($sformatf("vec%0d_greska", i), greska, tab[i].g);
    end

    // Negative feature at index 5 is clamped
    posalji_okvir(16'h0100, 1'b1, 5);
    chk("clamp_valid", bus.uzorak_valid, 1);
    chk("clamp_slot5", slot(5), 16'h0000);
    chk("clamp_slot4", slot(4), 16'h0104);
    chk("clamp_slot6", slot(6), 16'h0106);
    chk("clamp_greska1", greska[1], 1);
    korak(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
    chk("clamp_clear", greska, 0);

    // prvi at indeks 20 restarts the frame
    for (int k = 0; k < 20; k++) korak(1'b1, 16'h0200 + 16'(k), k == 0, 1'b0, 1'b1);
    chk("pr_indeks20", indeks, 20);
    chk("pr_greska_pre", greska, 0);
    korak(1'b1, 16'h0300, 1'b1, 1'b0, 1'b1);
    chk("pr_greska0", greska, 1);
    chk("pr_indeks1", indeks, 1);
    for (int k = 1; k < 60; k++) korak(1'b1, 16'h0300 + 16'(k), 1'b0, 1'b0, 1'b1);
    chk("pr_valid", bus.uzorak_valid, 1);
    chk_okvir("pr_frame", 16'h0300);
    korak(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
    chk("pr_clear", greska, 0);

    // Back-to-back frames with the consumer stalled
    posalji_okvir(16'h0400, 1'b0, 60);
    chk("bb_a_valid", bus.uzorak_valid, 1);
    nestabilno = 0;
    for (int k = 0; k < 59; k++) begin
      korak(1'b1, 16'h0500 + 16'(k), k == 0, 1'b0, 1'b0);
      if (bus.uzorak_valid !== 1'b1 || slot(0) !== 16'h0400 || slot(59) !== 16'h043B)
        nestabilno++;
    end
    chk("bb_a_stable", nestabilno, 0);
    chk("bb_indeks59", indeks, 59);
    chk("bb_rdy_low", bus.znacajka_ready, 0);
    korak(1'b1, 16'h053B, 1'b0, 1'b0, 1'b0);
    chk("bb_stall_indeks", indeks, 59);
    chk("bb_stall_hold", slot(59), 16'h043B);
    korak(1'b1, 16'h053B, 1'b0, 1'b0, 1'b1);
    chk("bb_b_valid", bus.uzorak_valid, 1);
    chk("bb_b_indeks", indeks, 0);
    chk_okvir("bb_b_frame", 16'h0500);
    korak(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    chk("bb_b_taken", bus.uzorak_valid, 0);
    chk("bb_b_hold", slot(0), 16'h0500);

    // Asynchronous reset mid-frame with a held output
    posalji_okvir(16'h0600, 1'b0, 60);
    for (int k = 0; k < 30; k++)
      korak(1'b1, (k == 3) ? 16'h8001 : 16'h0700 + 16'(k), k == 0, 1'b0, 1'b0);
    chk("mr_pre_indeks", indeks, 30);
    chk("mr_pre_valid", bus.uzorak_valid, 1);
    chk("mr_pre_greska", greska, 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_indeks", indeks, 0);
    chk("mr_valid", bus.uzorak_valid, 0);
    chk("mr_greska", greska, 0);
    chk("mr_uzorak_zero", bus.uzorak == '0, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("mr_no_pulse", bus.uzorak_valid, 0);
    posalji_okvir(16'h0800, 1'b1, 60);
    chk("mr_f_valid", bus.uzorak_valid, 1);
    chk_okvir("mr_frame", 16'h0800);
    chk("mr_f_greska", greska, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
